seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Each digit slot runs BLANK (all anodes off) -> LOAD (one cycle, latch the
// cathode pattern from the external nibble mux) -> ON (drive one anode).
// seg_sel advances on the ON->BLANK edge and selects the external mux input.
module seg_scan_ctrl #(
   parameter int ON_CYC    = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hold,
   input  logic [3:0] hex_in,
   input  logic [3:0] dp_in,
   input  logic [3:0] digit_en,
   output logic [1:0] seg_sel,
   output logic [3:0] anode,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_done
);

   typedef enum logic [1:0] {S_BLANK, S_LOAD, S_ON} state_t;

   localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYC - 1);
   localparam logic [19:0] ON_LAST    = 20'(ON_CYC - 1);

   state_t      state_q, state_d;
   logic [19:0] cnt_q, cnt_d;
   logic [1:0]  sel_q, sel_d;
   logic [3:0]  anode_q, anode_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic        frame_q, frame_d;
   logic [6:0]  dec;
   logic [3:0]  on_anode;

   // Hex nibble to active-low cathodes (seg[6]=a ... seg[0]=g).
   always_comb begin
      dec = 7'h7F;
      case (hex_in)
         4'h0: dec = 7'h01;  4'h1: dec = 7'h4F;  4'h2: dec = 7'h12;  4'h3: dec = 7'h06;
         4'h4: dec = 7'h4C;  4'h5: dec = 7'h24;  4'h6: dec = 7'h20;  4'h7: dec = 7'h0F;
         4'h8: dec = 7'h00;  4'h9: dec = 7'h04;  4'hA: dec = 7'h08;  4'hB: dec = 7'h60;
         4'hC: dec = 7'h31;  4'hD: dec = 7'h42;  4'hE: dec = 7'h30;  4'hF: dec = 7'h38;
         default: dec = 7'h7F;
      endcase
   end

   // Anode pattern for the selected digit; a disabled digit leaves all off.
   always_comb begin
      on_anode         = 4'hF;
      on_anode[sel_q]  = ~digit_en[sel_q];
   end

   // Next-state and registered-output logic; hold freezes everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      anode_d = anode_q;
      seg_d   = seg_q;
      dp_d    = dp_q;
      frame_d = 1'b0;
      if (!hold) begin
         case (state_q)
            S_BLANK: begin
               anode_d = 4'hF;
               if (cnt_q == BLANK_LAST) begin
                  state_d = S_LOAD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 20'd1;
               end
            end
            S_LOAD: begin
               seg_d   = dec;
               dp_d    = ~dp_in[sel_q];
               anode_d = on_anode;
               cnt_d   = '0;
               state_d = S_ON;
            end
            S_ON: begin
               if (cnt_q == ON_LAST) begin
                  state_d = S_BLANK;
                  cnt_d   = '0;
                  sel_d   = sel_q + 2'd1;
                  anode_d = 4'hF;
                  seg_d   = 7'h7F;
                  dp_d    = 1'b1;
                  frame_d = (sel_q == 2'd3);
               end else begin
                  cnt_d   = cnt_q + 20'd1;
                  anode_d = on_anode;
               end
            end
            default: begin
               state_d = S_BLANK;
               cnt_d   = '0;
               anode_d = 4'hF;
               seg_d   = 7'h7F;
               dp_d    = 1'b1;
            end
         endcase
      end
   end

   // State and output registers; reset overrides hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_BLANK;
         cnt_q   <= '0;
         sel_q   <= '0;
         anode_q <= 4'hF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         frame_q <= frame_d;
      end
   end

   assign seg_sel    = sel_q;
   assign anode      = anode_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with ON_CYC=4, BLANK_CYC=2 (period 7, frame 28).
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hold = 1'b0;
   logic [3:0] hex_in = 4'h0;
   logic [3:0] dp_in = 4'h0;
   logic [3:0] digit_en = 4'hF;
   logic [1:0] seg_sel;
   logic [3:0] anode;
   logic [6:0] seg;
   logic       dp;
   logic       frame_done;

   int errs = 0;
   int checks = 0;

   logic [6:0] dec_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   seg_scan_ctrl #(.ON_CYC(4), .BLANK_CYC(2)) dut (
      .clk(clk), .reset(reset), .hold(hold), .hex_in(hex_in), .dp_in(dp_in),
      .digit_en(digit_en), .seg_sel(seg_sel), .anode(anode), .seg(seg), .dp(dp),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Values sampled after this task are cycle 0.
   task automatic do_reset();
      reset = 1'b1;
      hold  = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // Free-run from reset, checking every cycle against the slot timeline.
   task automatic run_frame(input logic [3:0] en, input logic [3:0] hx, input logic [3:0] dpi,
                            input int ncyc);
      int p, d;
      logic [3:0] exp_an;
      logic       is_on;
      digit_en = en;
      hex_in   = hx;
      dp_in    = dpi;
      do_reset();
      for (int c = 0; c <= ncyc; c++) begin
         if (c > 0) tick();
         p      = c % 7;
         d      = (c / 7) % 4;
         is_on  = (p >= 3);
         exp_an = 4'hF;
         if (is_on) exp_an[d] = ~en[d];
         chk($sformatf("anode c%0d", c), 32'(anode), 32'(exp_an));
         chk($sformatf("seg c%0d", c), 32'(seg), is_on ? 32'(dec_tab[hx]) : 32'h7F);
         chk($sformatf("dp c%0d", c), 32'(dp), (is_on && !dpi[d]) || !is_on ? 32'd1 : 32'd0);
         chk($sformatf("sel c%0d", c), 32'(seg_sel), 32'(d));
         chk($sformatf("frame c%0d", c), 32'(frame_done), (c > 0 && c % 28 == 0) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      // Reset state.
      do_reset();
      chk("rst anode", 32'(anode), 32'hF);
      chk("rst seg", 32'(seg), 32'h7F);
      chk("rst dp", 32'(dp), 32'd1);
      chk("rst sel", 32'(seg_sel), 32'd0);
      chk("rst frame", 32'(frame_done), 32'd0);

      // Free run, hex 5: seg 24 from cycle 3, seg_sel 0..3,0, frame pulse at 28.
      run_frame(4'hF, 4'h5, 4'h0, 30);
      // Digit 2 disabled: its anode stays off.
      run_frame(4'b1011, 4'h3, 4'h0, 29);
      // Decimal point only on digit 1, hex A.
      run_frame(4'hF, 4'hA, 4'b0010, 29);

      // Hold for 5 cycles mid-ON of digit 2 (cycle 18 = second ON cycle).
      digit_en = 4'hF; hex_in = 4'h6; dp_in = 4'h0;
      do_reset();
      for (int c = 1; c <= 18; c++) tick();
      chk("hold pre anode", 32'(anode), 32'hB);
      hold = 1'b1;
      hex_in = 4'h1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("hold anode %0d", i), 32'(anode), 32'hB);
         chk($sformatf("hold seg %0d", i), 32'(seg), 32'h20);
         chk($sformatf("hold sel %0d", i), 32'(seg_sel), 32'd2);
      end
      hold = 1'b0;
      tick(); chk("rel anode 1", 32'(anode), 32'hB);
      tick(); chk("rel anode 2", 32'(anode), 32'hB);
      tick(); chk("rel anode 3", 32'(anode), 32'hF);
      chk("rel sel", 32'(seg_sel), 32'd3);
      chk("rel seg", 32'(seg), 32'h7F);

      // Hold and reset together mid-ON: reset wins.
      tick(); tick(); tick(); tick();
      chk("hr pre anode", 32'(anode), 32'h7);
      hold = 1'b1; reset = 1'b1;
      tick();
      hold = 1'b0; reset = 1'b0;
      chk("hr anode", 32'(anode), 32'hF);
      chk("hr seg", 32'(seg), 32'h7F);
      chk("hr dp", 32'(dp), 32'd1);
      chk("hr sel", 32'(seg_sel), 32'd0);

      // Hold on the frame_done cycle forces it low and freezes seg_sel.
      do_reset();
      for (int c = 1; c <= 28; c++) tick();
      chk("fd pulse", 32'(frame_done), 32'd1);
      hold = 1'b1;
      tick();
      chk("fd held", 32'(frame_done), 32'd0);
      chk("fd held sel", 32'(seg_sel), 32'd0);
      hold = 1'b0;
      tick();
      chk("fd after", 32'(frame_done), 32'd0);

      // hex_in change mid-ON is ignored until next LOAD; mid-ON digit_en takes effect next clock.
      hex_in = 4'h0; digit_en = 4'hF;
      do_reset();
      for (int c = 1; c <= 4; c++) tick();
      chk("hx seg c4", 32'(seg), 32'h01);
      hex_in = 4'h8;
      digit_en = 4'hE;
      tick();
      chk("hx seg c5", 32'(seg), 32'h01);
      chk("en off c5", 32'(anode), 32'hF);
      digit_en = 4'hF;
      tick();
      chk("hx seg c6", 32'(seg), 32'h01);
      chk("en on c6", 32'(anode), 32'hE);
      tick();
      chk("hx seg c7", 32'(seg), 32'h7F);
      tick(); tick(); tick();
      chk("hx seg c10", 32'(seg), 32'h00);
      chk("hx anode c10", 32'(anode), 32'hD);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   // Absolute time bound so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded bound");
      $fatal(1);
   end

endmodule
